// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a single carry register,
// with valid/ready handshakes on both sides and carry/borrow plus signed-overflow flags.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned DG    = (DIGIT == 0) ? 1 : DIGIT;
    localparam int unsigned N     = WIDTH / DG;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject parameter sets that would otherwise silently truncate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DG) != 0) begin : g_bad_params
        $fatal(1, "serial_adder: WIDTH must be >= 2 and divisible by DIGIT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               carry;
    logic               a_msb;
    logic               b_msb;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   b_eff;
    logic [DIGIT:0]     digit_sum;
    logic [WIDTH-1:0]   res_next;

    // One digit slice per cycle; the new slice enters the result from the MSB end
    always_comb begin
        b_eff     = sub ? ~b : b;
        digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res_next  = WIDTH'({digit_sum[DIGIT-1:0], res_sh} >> DIGIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b_eff;
                        carry    <= sub ? ~cin : cin;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b_eff[WIDTH-1];
                        res_sh   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= digit_sum[DIGIT];
                    res_sh <= res_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        sum       <= res_next;
                        cout      <= digit_sum[DIGIT];
                        overflow  <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Handoff returns to IDLE; the next accept is at least one cycle later
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
